// File: rtl/md_sequencer_pkg.sv
// Shared encodings for the multiply/divide sequencer: MD operation codes,
// FSM states and small opcode classification helpers.
package md_sequencer_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   function automatic logic is_arith(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic is_div(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// E/D-stage handshake between the pipeline and the multiply/divide sequencer.
interface md_sequencer_if;

   logic        Start_E;
   logic [2:0]  MDOp_E;
   logic [31:0] OprandA_E;
   logic [31:0] OprandB_E;
   logic        MDUse_D;
   logic        Busy;
   logic        Stall_MD;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output Start_E, MDOp_E, OprandA_E, OprandB_E, MDUse_D,
      input  Busy, Stall_MD, HI, LO
   );

   modport slave (
      input  Start_E, MDOp_E, OprandA_E, OprandB_E, MDUse_D,
      output Busy, Stall_MD, HI, LO
   );

endinterface

// File: rtl/md_sequencer_compute.sv
// Combinational multiply/divide datapath: returns {HI,LO}-shaped 64-bit result
// ({remainder,quotient} for divides) plus a divide-by-zero flag.
module md_compute
   import md_sequencer_pkg::*;
(
   input  logic [2:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [63:0] res_o,
   output logic        div0_o
);

   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic        [31:0] divisor;
   logic signed [31:0] quot_s;
   logic signed [31:0] rem_s;
   logic        [31:0] quot_u;
   logic        [31:0] rem_u;

   assign div0_o  = (b_i == '0);
   // Substitute divisor keeps the divider X-free; the result is discarded on div0.
   assign divisor = div0_o ? 32'd1 : b_i;

   assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
   assign prod_u = {32'd0, a_i} * {32'd0, b_i};
   assign quot_s = $signed(a_i) / $signed(divisor);
   assign rem_s  = $signed(a_i) % $signed(divisor);
   assign quot_u = a_i / divisor;
   assign rem_u  = a_i % divisor;

   always_comb begin
      res_o = '0;
      case (op_i)
         MD_MULT:  res_o = $unsigned(prod_s);
         MD_MULTU: res_o = prod_u;
         MD_DIV:   res_o = {$unsigned(rem_s), $unsigned(quot_s)};
         MD_DIVU:  res_o = {rem_u, quot_u};
         default:  res_o = '0;
      endcase
   end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide controller: computes at issue, holds the result
// pending for a fixed latency, then commits HI/LO; drives the D-stage stall.
module md_sequencer
   import md_sequencer_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10,
   parameter int unsigned CNT_W       = 4
) (
   input  logic          clk,
   input  logic          reset,
   md_sequencer_if.slave md
);

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      ph_q, ph_d;
   logic [31:0]      pl_q, pl_d;
   logic             skip_q, skip_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;

   logic [63:0]      res;
   logic             div0;
   logic             busy;
   logic             start_arith;

   md_compute u_compute (
      .op_i   (md.MDOp_E),
      .a_i    (md.OprandA_E),
      .b_i    (md.OprandB_E),
      .res_o  (res),
      .div0_o (div0)
   );

   assign busy        = (state_q == ST_RUN);
   assign start_arith = md.Start_E & is_arith(md.MDOp_E);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ph_d    = ph_q;
      pl_d    = pl_q;
      skip_d  = skip_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (start_arith) begin
               state_d    = ST_RUN;
               {ph_d, pl_d} = res;
               // A multiply by zero is a valid result; only divides skip the commit.
               skip_d     = div0 & is_div(md.MDOp_E);
               cnt_d      = is_div(md.MDOp_E) ? DIV_LOAD : MULT_LOAD;
            end else if (md.Start_E && md.MDOp_E == MD_MTHI) begin
               hi_d = md.OprandA_E;
            end else if (md.Start_E && md.MDOp_E == MD_MTLO) begin
               lo_d = md.OprandA_E;
            end
         end
         ST_RUN: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               if (!skip_q) begin
                  hi_d = ph_q;
                  lo_d = pl_q;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ph_q    <= '0;
         pl_q    <= '0;
         skip_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ph_q    <= ph_d;
         pl_q    <= pl_d;
         skip_q  <= skip_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign md.Busy     = busy;
   assign md.Stall_MD = md.MDUse_D & (busy | start_arith);
   assign md.HI       = hi_q;
   assign md.LO       = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer: vector table plus hand-written
// stall and mid-operation reset sequences.
module tb_md_sequencer;
   import md_sequencer_pkg::*;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int unsigned cyc;
   } vec_t;

   logic clk;
   logic reset;
   int unsigned n_checks;
   int unsigned n_fail;

   md_sequencer_if mdif ();

   md_sequencer #(
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10),
      .CNT_W       (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .md    (mdif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   vec_t        vecs[15];
   logic [31:0] prev_hi, prev_lo;
   int unsigned n;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      vecs[0]  = '{MD_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
      vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
      vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      vecs[3]  = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       10};
      vecs[4]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
      vecs[5]  = '{MD_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 10};
      vecs[6]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
      vecs[7]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
      vecs[8]  = '{MD_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 5};
      vecs[9]  = '{MD_MTHI,  32'h00001234, 32'hDEADBEEF, 32'h00001234, 32'hFFFFFFEB, 0};
      vecs[10] = '{MD_MTLO,  32'h00005678, 32'hDEADBEEF, 32'h00001234, 32'h00005678, 0};
      vecs[11] = '{MD_DIVU,  32'd9,        32'd0,        32'h00001234, 32'h00005678, 10};
      vecs[12] = '{MD_DIV,   32'd9,        32'd0,        32'h00001234, 32'h00005678, 10};
      vecs[13] = '{MD_NONE,  32'h0000FFFF, 32'd3,        32'h00001234, 32'h00005678, 0};
      vecs[14] = '{3'b111,   32'h0000FFFF, 32'd3,        32'h00001234, 32'h00005678, 0};

      reset          = 1'b0;
      mdif.Start_E   = 1'b0;
      mdif.MDOp_E    = MD_NONE;
      mdif.OprandA_E = '0;
      mdif.OprandB_E = '0;
      mdif.MDUse_D   = 1'b1;
      #12;
      check("reset_hi",    mdif.HI, 32'h0);
      check("reset_lo",    mdif.LO, 32'h0);
      check("reset_busy",  {31'd0, mdif.Busy}, 32'd0);
      check("reset_stall", {31'd0, mdif.Stall_MD}, 32'd0);
      reset        = 1'b1;
      mdif.MDUse_D = 1'b0;
      tick();

      prev_hi = 32'h0;
      prev_lo = 32'h0;
      for (int i = 0; i < 15; i++) begin
         mdif.Start_E   = 1'b1;
         mdif.MDOp_E    = vecs[i].op;
         mdif.OprandA_E = vecs[i].a;
         mdif.OprandB_E = vecs[i].b;
         tick();
         mdif.Start_E = 1'b0;
         mdif.MDOp_E  = MD_NONE;
         if (vecs[i].cyc > 0) begin
            check($sformatf("vec%0d_hold_hi", i), mdif.HI, prev_hi);
            check($sformatf("vec%0d_hold_lo", i), mdif.LO, prev_lo);
            check($sformatf("vec%0d_nostall", i), {31'd0, mdif.Stall_MD}, 32'd0);
         end
         n = 0;
         while (mdif.Busy && n < 40) begin
            n++;
            tick();
         end
         check($sformatf("vec%0d_busy_cycles", i), n, vecs[i].cyc);
         check($sformatf("vec%0d_hi", i), mdif.HI, vecs[i].hi);
         check($sformatf("vec%0d_lo", i), mdif.LO, vecs[i].lo);
         prev_hi = vecs[i].hi;
         prev_lo = vecs[i].lo;
      end

      // Stall window with a mflo waiting in D; a div issued mid-run must be dropped.
      mdif.MDUse_D = 1'b1;
      #1;
      check("stall_idle", {31'd0, mdif.Stall_MD}, 32'd0);
      mdif.Start_E   = 1'b1;
      mdif.MDOp_E    = MD_MULT;
      mdif.OprandA_E = 32'd3;
      mdif.OprandB_E = 32'd5;
      #1;
      check("stall_start_cycle", {31'd0, mdif.Stall_MD}, 32'd1);
      tick();
      mdif.Start_E = 1'b0;
      mdif.MDOp_E  = MD_NONE;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("stall_busy%0d", i), {31'd0, mdif.Stall_MD}, 32'd1);
         check($sformatf("busy_run%0d", i), {31'd0, mdif.Busy}, 32'd1);
         if (i == 1) begin
            mdif.Start_E   = 1'b1;
            mdif.MDOp_E    = MD_DIV;
            mdif.OprandA_E = 32'd100;
            mdif.OprandB_E = 32'd3;
         end else begin
            mdif.Start_E = 1'b0;
            mdif.MDOp_E  = MD_NONE;
         end
         tick();
      end
      check("stall_after_busy", {31'd0, mdif.Stall_MD}, 32'd0);
      check("stall_busy_fell",  {31'd0, mdif.Busy}, 32'd0);
      check("stall_lo", mdif.LO, 32'd15);
      check("stall_hi", mdif.HI, 32'd0);
      n = 0;
      for (int i = 0; i < 12; i++) begin
         if (mdif.Busy) n++;
         tick();
      end
      check("ignored_div_busy", n, 0);
      check("ignored_div_lo", mdif.LO, 32'd15);
      check("ignored_div_hi", mdif.HI, 32'd0);
      mdif.MDUse_D = 1'b0;

      // Asynchronous reset in the middle of a divide.
      mdif.Start_E   = 1'b1;
      mdif.MDOp_E    = MD_DIV;
      mdif.OprandA_E = 32'd100;
      mdif.OprandB_E = 32'd7;
      tick();
      mdif.Start_E = 1'b0;
      mdif.MDOp_E  = MD_NONE;
      tick();
      tick();
      tick();
      #3;
      reset = 1'b0;
      #1;
      check("midrst_hi",   mdif.HI, 32'd0);
      check("midrst_lo",   mdif.LO, 32'd0);
      check("midrst_busy", {31'd0, mdif.Busy}, 32'd0);
      #1;
      reset = 1'b1;
      n = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (mdif.Busy) n++;
      end
      check("postrst_busy", n, 0);
      check("postrst_hi", mdif.HI, 32'd0);
      check("postrst_lo", mdif.LO, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
